// File: rtl/rgb2hsv_pkg.sv
// Shared types and constants for the RGB to HSV converter: controller state
// encoding, dominant-channel code, angle/scale constants and the final hue
// assembly helper.
package rgb2hsv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CAPTURE  = 4'd1,
        ST_SAT_REQ  = 4'd2,
        ST_SAT_WAIT = 4'd3,
        ST_SAT_REL  = 4'd4,
        ST_HUE_REQ  = 4'd5,
        ST_HUE_WAIT = 4'd6,
        ST_HUE_REL  = 4'd7,
        ST_OUT      = 4'd8
    } state_e;

    // Which channel holds the maximum; ties resolve R first, then G.
    typedef enum logic [1:0] {
        DOM_R = 2'd0,
        DOM_G = 2'd1,
        DOM_B = 2'd2
    } dom_e;

    localparam logic [8:0] HUE_SPAN  = 9'd60;
    localparam logic [8:0] HUE_OFF_G = 9'd120;
    localparam logic [8:0] HUE_OFF_B = 9'd240;
    localparam logic [7:0] SAT_SCALE = 8'd255;
    localparam logic [8:0] HUE_FULL  = 9'd360;

    // Combine the sector offset with the signed hue quotient and wrap into
    // 0..359. Only the red sector can go negative (off = 0), so the wrap
    // adds a full turn before subtracting to stay in unsigned 9-bit range.
    function automatic logic [8:0] hue_combine(input dom_e dom,
                                               input logic neg,
                                               input logic [6:0] q);
        logic [8:0] off;
        logic [8:0] q9;
        logic [8:0] res;
        q9 = {2'b00, q};
        case (dom)
            DOM_G:   off = HUE_OFF_G;
            DOM_B:   off = HUE_OFF_B;
            default: off = 9'd0;
        endcase
        if (!neg) begin
            res = off + q9;
        end else if (off >= q9) begin
            res = off - q9;
        end else begin
            res = off + HUE_FULL - q9;
        end
        if (res == HUE_FULL) begin
            res = 9'd0;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb_max_min.sv
// Combinational max/min finder over one RGB pixel, also reporting which
// channel is the maximum (R wins ties over G, G over B).
module rgb_max_min
    import rgb2hsv_pkg::*;
(
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic [7:0] max_o,
    output logic [7:0] min_o,
    output dom_e       dom_o
);

    // Largest channel and its identity, tie priority R > G > B.
    always_comb begin
        if ((r_i >= g_i) && (r_i >= b_i)) begin
            max_o = r_i;
            dom_o = DOM_R;
        end else if (g_i >= b_i) begin
            max_o = g_i;
            dom_o = DOM_G;
        end else begin
            max_o = b_i;
            dom_o = DOM_B;
        end
    end

    // Smallest channel.
    always_comb begin
        if ((r_i <= g_i) && (r_i <= b_i)) begin
            min_o = r_i;
        end else if (g_i <= b_i) begin
            min_o = g_i;
        end else begin
            min_o = b_i;
        end
    end

endmodule

// File: rtl/rgb2hsv_ctrl.sv
// RGB to HSV converter controller. Captures a pixel, finds max/min, then
// uses an external divider (enable/done four-phase handshake) once for
// saturation and once for hue, and presents h/s/v until the consumer takes
// them. Gray and black pixels need no division and skip straight to OUT.
module rgb2hsv_ctrl
    import rgb2hsv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  h,
    output logic [7:0]  s,
    output logic [7:0]  v,
    output logic        div_enable,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_quot
);

    state_e      state_q, state_d;
    logic [7:0]  r_q, g_q, b_q;
    logic [7:0]  max_q, delta_q;
    dom_e        dom_q;
    logic [7:0]  sat_q;
    logic [6:0]  hue_q;
    logic        neg_q;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        div_en_q, div_en_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic [8:0]  h_q;
    logic [7:0]  s_q, v_q;

    logic [7:0]  mm_max_s, mm_min_s, mm_delta_s;
    dom_e        mm_dom_s;
    logic [7:0]  diff_pos_s, diff_sub_s, diff_abs_s;
    logic        diff_neg_s;
    logic [7:0]  sat_quot_s;
    logic [6:0]  hue_quot_s;

    rgb_max_min u_max_min (
        .r_i   (r_q),
        .g_i   (g_q),
        .b_i   (b_q),
        .max_o (mm_max_s),
        .min_o (mm_min_s),
        .dom_o (mm_dom_s)
    );

    assign mm_delta_s = mm_max_s - mm_min_s;

    // Signed hue difference for the dominant sector, kept as sign + magnitude.
    always_comb begin
        case (dom_q)
            DOM_G: begin
                diff_pos_s = b_q;
                diff_sub_s = r_q;
            end
            DOM_B: begin
                diff_pos_s = r_q;
                diff_sub_s = g_q;
            end
            default: begin
                diff_pos_s = g_q;
                diff_sub_s = b_q;
            end
        endcase
        diff_neg_s = (diff_pos_s < diff_sub_s);
        if (diff_neg_s) begin
            diff_abs_s = diff_sub_s - diff_pos_s;
        end else begin
            diff_abs_s = diff_pos_s - diff_sub_s;
        end
    end

    // Clamp divider quotients to their mathematically possible ranges so a
    // misbehaving divider can never produce an out-of-range s or h.
    always_comb begin
        if (div_quot[31:8] != 24'd0) begin
            sat_quot_s = SAT_SCALE;
        end else begin
            sat_quot_s = div_quot[7:0];
        end
        if ((div_quot[31:7] != 25'd0) || (div_quot[6:0] > HUE_SPAN[6:0])) begin
            hue_quot_s = HUE_SPAN[6:0];
        end else begin
            hue_quot_s = div_quot[6:0];
        end
    end

    // Next-state logic. A zero delta means s = 0 and h = 0 exactly, so both
    // divisions are skipped (this also covers max == 0).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) state_d = ST_CAPTURE;
                else                        state_d = ST_IDLE;
            end
            ST_CAPTURE: begin
                if ((mm_max_s != 8'd0) && (mm_delta_s != 8'd0)) state_d = ST_SAT_REQ;
                else                                            state_d = ST_OUT;
            end
            ST_SAT_REQ:  state_d = ST_SAT_WAIT;
            ST_SAT_WAIT: begin
                if (div_done) state_d = ST_SAT_REL;
                else          state_d = ST_SAT_WAIT;
            end
            ST_SAT_REL: begin
                if (div_done)               state_d = ST_SAT_REL;
                else if (delta_q != 8'd0)   state_d = ST_HUE_REQ;
                else                        state_d = ST_OUT;
            end
            ST_HUE_REQ:  state_d = ST_HUE_WAIT;
            ST_HUE_WAIT: begin
                if (div_done) state_d = ST_HUE_REL;
                else          state_d = ST_HUE_WAIT;
            end
            ST_HUE_REL: begin
                if (div_done) state_d = ST_HUE_REL;
                else          state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) state_d = ST_IDLE;
                else                          state_d = ST_OUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered handshake/divider controls derived from the next state, so
    // they line up with the state register and reset clears them at once.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_q == ST_OUT) && (state_d == ST_OUT);
        div_en_d    = (state_d == ST_SAT_REQ) || (state_d == ST_SAT_WAIT) ||
                      (state_d == ST_HUE_REQ) || (state_d == ST_HUE_WAIT);
    end

    // Divider operands: loaded on entry to a REQ state, held otherwise.
    always_comb begin
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        if ((state_q == ST_CAPTURE) && (state_d == ST_SAT_REQ)) begin
            div_a_d = {24'd0, mm_delta_s} * {24'd0, SAT_SCALE};
            div_b_d = {24'd0, mm_max_s};
        end else if ((state_q == ST_SAT_REL) && (state_d == ST_HUE_REQ)) begin
            div_a_d = {24'd0, diff_abs_s} * {23'd0, HUE_SPAN};
            div_b_d = {24'd0, delta_q};
        end else begin
            div_a_d = div_a_q;
            div_b_d = div_b_q;
        end
    end

    // State and interface registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            div_en_q    <= 1'b0;
            div_a_q     <= 32'd0;
            div_b_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            div_en_q    <= div_en_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
        end
    end

    // Pixel capture, max/min/delta capture and divider quotient capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            b_q     <= 8'd0;
            max_q   <= 8'd0;
            delta_q <= 8'd0;
            dom_q   <= DOM_R;
            sat_q   <= 8'd0;
            hue_q   <= 7'd0;
            neg_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && in_valid && in_ready_q) begin
                r_q <= r;
                g_q <= g;
                b_q <= b;
            end
            if (state_q == ST_CAPTURE) begin
                max_q   <= mm_max_s;
                delta_q <= mm_delta_s;
                dom_q   <= mm_dom_s;
                sat_q   <= 8'd0;
                hue_q   <= 7'd0;
            end
            if ((state_q == ST_SAT_REL) && (state_d == ST_HUE_REQ)) begin
                neg_q <= diff_neg_s;
            end
            if ((state_q == ST_SAT_WAIT) && div_done) begin
                sat_q <= sat_quot_s;
            end
            if ((state_q == ST_HUE_WAIT) && div_done) begin
                hue_q <= hue_quot_s;
            end
        end
    end

    // Result registers: loaded in the first OUT cycle, frozen until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= 9'd0;
            s_q <= 8'd0;
            v_q <= 8'd0;
        end else if ((state_q == ST_OUT) && !out_valid_q) begin
            v_q <= max_q;
            s_q <= (max_q == 8'd0) ? 8'd0 : sat_q;
            h_q <= (delta_q == 8'd0) ? 9'd0 : hue_combine(dom_q, neg_q, hue_q);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign div_enable = div_en_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign h          = h_q;
    assign s          = s_q;
    assign v          = v_q;

endmodule

// File: tb/tb_rgb2hsv_ctrl.sv
// Directed bench for rgb2hsv_ctrl: vector table of pixels with hand-computed
// HSV results, a simple behavioural divider, plus output-hold and
// reset-during-division sequences.
module tb_rgb2hsv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  h;
    logic [7:0]  s, v;
    logic        div_enable;
    logic [31:0] div_a, div_b;
    logic        div_done;
    logic [31:0] div_quot;

    int checks = 0;
    int errors = 0;

    logic        div_manual = 1'b0;
    logic        man_done = 1'b0;
    logic [31:0] man_quot = 32'd0;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_quot = 32'd0;
    int          req_count = 0;

    assign div_done = div_manual ? man_done : mdl_done;
    assign div_quot = div_manual ? man_quot : mdl_quot;

    rgb2hsv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .r          (r),
        .g          (g),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .h          (h),
        .s          (s),
        .v          (v),
        .div_enable (div_enable),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_quot   (div_quot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
        int         ndiv;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: answers 3 cycles after a request, holds done
    // until enable drops; counts requests and checks operand stability.
    logic        en_prev = 1'b0;
    logic [31:0] a_hold = 32'd0, b_hold = 32'd0;
    int          lat_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (div_enable && !en_prev) begin
            req_count++;
            a_hold = div_a;
            b_hold = div_b;
        end else if (div_enable && en_prev) begin
            chk("div_a_stable", div_a, a_hold);
            chk("div_b_stable", div_b, b_hold);
        end
        if (!div_enable) begin
            mdl_done = 1'b0;
            lat_cnt  = 0;
        end else if (!mdl_done) begin
            lat_cnt++;
            if (lat_cnt >= 3) begin
                mdl_quot = (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
                mdl_done = 1'b1;
            end
        end
        en_prev = div_enable;
    end

    task automatic send_pixel(input logic [7:0] pr, input logic [7:0] pg,
                              input logic [7:0] pb, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        req_count = 0;
        r = pr; g = pg; b = pb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin : main
        int lat;
        int n;
        logic [8:0] h0;
        logic [7:0] s0, v0;

        vecs[0] = '{8'd255, 8'd0,   8'd0,   9'd0,   8'd255, 8'd255, 2};
        vecs[1] = '{8'd0,   8'd255, 8'd0,   9'd120, 8'd255, 8'd255, 2};
        vecs[2] = '{8'd0,   8'd0,   8'd255, 9'd240, 8'd255, 8'd255, 2};
        vecs[3] = '{8'd200, 8'd100, 8'd50,  9'd20,  8'd191, 8'd200, 2};
        vecs[4] = '{8'd255, 8'd0,   8'd128, 9'd330, 8'd255, 8'd255, 2};
        vecs[5] = '{8'd128, 8'd128, 8'd128, 9'd0,   8'd0,   8'd128, 0};
        vecs[6] = '{8'd0,   8'd0,   8'd0,   9'd0,   8'd0,   8'd0,   0};

        // Reset state.
        #2;
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_div_enable", 32'(div_enable), 32'd0);
        chk("rst_div_a",      div_a,           32'd0);
        chk("rst_div_b",      div_b,           32'd0);
        chk("rst_h",          32'(h),          32'd0);
        chk("rst_s",          32'(s),          32'd0);
        chk("rst_v",          32'(v),          32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_pre_clk", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_first_clk", 32'(in_ready), 32'd1);

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            send_pixel(vecs[i].r, vecs[i].g, vecs[i].b, lat);
            chk("h", 32'(h), 32'(vecs[i].h));
            chk("s", 32'(s), 32'(vecs[i].s));
            chk("v", 32'(v), 32'(vecs[i].v));
            chk("div_requests", 32'(req_count), 32'(vecs[i].ndiv));
            if (vecs[i].ndiv == 0) begin
                chk("nodiv_latency", 32'(lat), 32'd2);
            end
            if (i == 4) begin
                h0 = h; s0 = s; v0 = v;
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_h", 32'(h), 32'(h0));
                    chk("hold_s", 32'(s), 32'(s0));
                    chk("hold_v", 32'(v), 32'(v0));
                    chk("hold_out_valid", 32'(out_valid), 32'd1);
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                end
            end
            release_result();
        end

        // Reset while waiting on the saturation division.
        div_manual = 1'b1;
        man_done   = 1'b0;
        @(negedge clk);
        r = 8'd255; g = 8'd0; b = 8'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!div_enable && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sat_req_seen", 32'(div_enable), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("sat_wait_enable", 32'(div_enable), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_div_enable", 32'(div_enable), 32'd0);
        chk("rst_async_in_ready",   32'(in_ready),   32'd0);
        chk("rst_async_div_a",      div_a,           32'd0);
        chk("rst_async_out_valid",  32'(out_valid),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        man_quot = 32'd77;
        man_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("late_done_div_enable", 32'(div_enable), 32'd0);
            chk("late_done_out_valid",  32'(out_valid),  32'd0);
            chk("late_done_s",          32'(s),          32'd0);
        end
        @(negedge clk);
        man_done   = 1'b0;
        div_manual = 1'b0;

        send_pixel(8'd200, 8'd100, 8'd50, lat);
        chk("post_rst_h", 32'(h), 32'd20);
        chk("post_rst_s", 32'(s), 32'd191);
        chk("post_rst_v", 32'(v), 32'd200);
        chk("post_rst_div_requests", 32'(req_count), 32'd2);
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
